ov7670_fb_writer: RTL and testbench



---
 rtl/ov7670_pkg.sv | 43 ++++
 rtl/ov7670_fb_addrgen.sv | 76 +++++++
 rtl/ov7670_fb_writer.sv | 131 +++++++++++++
 tb/tb_ov7670_fb_writer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and geometry helpers for the OV7670 frame-buffer writer.
// Build option: define FB_DBUF_EN to enable double buffering; the default build
// is a single buffer.
package ov7670_pkg;

    // Sensor defaults (VGA).
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

`ifdef FB_DBUF_EN
    localparam bit FB_DBUF = 1'b1;
`else
    localparam bit FB_DBUF = 1'b0;
`endif

    // Writer FSM states.
    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } fbw_state_t;

    // Decimated output geometry and BRAM address width.
    typedef struct packed {
        int unsigned ow;
        int unsigned oh;
        int unsigned aw;
    } fb_geom_t;

    // Output width/height after decimation, and address width covering one
    // bank (single buffer) or two banks (double buffer).
    function automatic fb_geom_t fb_geom(input int width, input int height,
                                         input int shift, input bit dbuf);
        fb_geom_t    g;
        int unsigned cells;
        g.ow  = int'(width  >> shift);
        g.oh  = int'(height >> shift);
        cells = dbuf ? 2 * g.ow * g.oh : g.ow * g.oh;
        g.aw  = (cells > 1) ? $clog2(cells) : 1;
        return g;
    endfunction

endpackage

// File: rtl/ov7670_fb_addrgen.sv
// Address generator: tracks the output row base, the row counter and the
// write bank, and flags the pixel that completes a frame. x comes straight
// from the column counter, so no multiplier is needed anywhere.
// Build option: FB_DBUF_EN enables the second bank and bank toggling.
module ov7670_fb_addrgen
    import ov7670_pkg::*;
#(
    parameter  int       WIDTH       = DEF_WIDTH,
    parameter  int       HEIGHT      = DEF_HEIGHT,
    parameter  int       SCALE_SHIFT = 1,
    localparam fb_geom_t GEOM        = fb_geom(WIDTH, HEIGHT, SCALE_SHIFT, FB_DBUF),
    localparam int       AW          = int'(GEOM.aw),
    localparam int       HW          = $clog2(WIDTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,   // restart at row 0 of the current bank
    input  logic          adv_i,     // a kept pixel is being written this cycle
    input  logic [HW-1:0] h_cnt_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o,    // the kept pixel completes the frame
    output logic          wr_bank_o
);

    localparam int OW = int'(GEOM.ow);
    localparam int OH = int'(GEOM.oh);
    localparam int VW = $clog2(HEIGHT) + 1;

    logic [AW-1:0] row_base_q;
    logic [VW-1:0] y_q;
    logic [HW-1:0] x;
    logic          x_last;
    logic          y_last;
    logic [AW-1:0] bank_off;

`ifdef FB_DBUF_EN
    logic wr_bank_q;
    assign bank_off  = wr_bank_q ? AW'(OW * OH) : '0;
    assign wr_bank_o = wr_bank_q;
`else
    assign bank_off  = '0;
    assign wr_bank_o = 1'b0;
`endif

    assign x      = h_cnt_i >> SCALE_SHIFT;
    assign x_last = (x == HW'(OW - 1));
    assign y_last = (y_q == VW'(OH - 1));
    assign last_o = adv_i && x_last && y_last;
    assign addr_o = bank_off + row_base_q + AW'(x);

    // Row base / row counter: cleared while armed, stepped at the end of each kept row.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            row_base_q <= '0;
            y_q        <= '0;
        end else if (clear_i) begin
            row_base_q <= '0;
            y_q        <= '0;
        end else if (adv_i && x_last) begin
            row_base_q <= row_base_q + AW'(OW);
            y_q        <= y_q + VW'(1);
        end
    end

`ifdef FB_DBUF_EN
    // Write bank flips only on a completed frame; aborts leave it alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_bank_q <= 1'b0;
        end else if (last_o) begin
            wr_bank_q <= ~wr_bank_q;
        end
    end
`endif

endmodule

// File: rtl/ov7670_fb_writer.sv
// Frame-buffer write controller for the OV7670 capture path. Decimates the
// RGB565 stream by 2^SCALE_SHIFT in both axes, writes kept pixels to a BRAM
// port one cycle later, pulses frame_done on the last write, and counts
// frames aborted by an early VSYNC.
// Build option: define FB_DBUF_EN for double buffering (fb_bank_rd then names
// the last completed bank); otherwise a single buffer with fb_bank_rd = 0.
module ov7670_fb_writer
    import ov7670_pkg::*;
#(
    parameter  int       WIDTH       = DEF_WIDTH,
    parameter  int       HEIGHT      = DEF_HEIGHT,
    parameter  int       SCALE_SHIFT = 1,
    parameter  int       DATA_WIDTH  = 16,
    localparam fb_geom_t GEOM        = fb_geom(WIDTH, HEIGHT, SCALE_SHIFT, FB_DBUF),
    localparam int       AW          = int'(GEOM.aw),
    localparam int       HW          = $clog2(WIDTH) + 1,
    localparam int       VW          = $clog2(HEIGHT) + 1
) (
    input  logic                  cam_PCLK,
    input  logic                  cam_RESETn,
    input  logic                  cam_VSYNC,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] rgb565,
    input  logic [HW-1:0]         h_cnt,
    input  logic [VW-1:0]         v_cnt,
    output logic                  fb_we,
    output logic [AW-1:0]         fb_addr,
    output logic [DATA_WIDTH-1:0] fb_wdata,
    output logic                  frame_done,
    output logic                  fb_bank_rd,
    output logic [7:0]            drop_cnt
);

    localparam logic [HW-1:0] H_MASK = HW'((1 << SCALE_SHIFT) - 1);
    localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);

    fbw_state_t            state_q, state_d;
    logic                  done_q, done_d;
    logic                  we_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  frame_done_q;
    logic                  bank_rd_q;
    logic [7:0]            drop_q;

    logic                  in_range;
    logic                  aligned;
    logic                  keep;
    logic                  abort;
    logic [AW-1:0]         addr_next;
    logic                  frame_last;
    logic                  wr_bank;

    // Keep filter: VSYNC in CAPTURE wins over a coincident pixel.
    assign in_range = (h_cnt < HW'(WIDTH)) && (v_cnt < VW'(HEIGHT));
    assign aligned  = ((h_cnt & H_MASK) == '0) && ((v_cnt & V_MASK) == '0);
    assign keep     = pix_valid && (state_q == CAPTURE) && !cam_VSYNC && in_range && aligned;
    assign abort    = (state_q == CAPTURE) && cam_VSYNC;

    ov7670_fb_addrgen #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_addrgen (
        .clk_i     (cam_PCLK),
        .rst_ni    (cam_RESETn),
        .clear_i   (state_q == ARMED),
        .adv_i     (keep),
        .h_cnt_i   (h_cnt),
        .addr_o    (addr_next),
        .last_o    (frame_last),
        .wr_bank_o (wr_bank)
    );

    // Next-state logic. done_q blocks re-arming after a completed frame
    // until VSYNC has been seen high again, so trailing pixels are dropped.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        done_d  = done_q;
        if (cam_VSYNC) begin
            done_d = 1'b0;
        end else if (frame_last) begin
            done_d = 1'b1;
        end
        unique case (state_q)
            WAIT_VS: if (cam_VSYNC)               state_d = ARMED;
            ARMED:   if (!cam_VSYNC && !done_q)   state_d = CAPTURE;
            CAPTURE: if (cam_VSYNC || frame_last) state_d = ARMED;
            default:                              state_d = WAIT_VS;
        endcase
    end

    // State, output registers and drop counter; synchronous active-low reset.
    always_ff @(posedge cam_PCLK) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!cam_RESETn) begin
            state_q      <= WAIT_VS;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            bank_rd_q    <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            we_q         <= keep;
            frame_done_q <= frame_last;
            if (keep) begin
                addr_q  <= addr_next;
                wdata_q <= rgb565;
            end
            if (frame_last) begin
                bank_rd_q <= wr_bank;
            end
            if (abort && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign fb_we      = we_q;
    assign fb_addr    = addr_q;
    assign fb_wdata   = wdata_q;
    assign frame_done = frame_done_q;
    assign fb_bank_rd = bank_rd_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_ov7670_fb_writer.sv
// Directed bench for ov7670_fb_writer on a reduced 16x8 sensor with
// SCALE_SHIFT=1 (8x4 output, 32 writes per frame). Honors FB_DBUF_EN.
module tb_ov7670_fb_writer;

    localparam int W     = 16;
    localparam int H     = 8;
    localparam int FRAME = 32;
`ifdef FB_DBUF_EN
    localparam int AW    = 6;
    localparam bit DBUF  = 1'b1;
`else
    localparam int AW    = 5;
    localparam bit DBUF  = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          vsync;
    logic          pix_valid;
    logic [15:0]   rgb565;
    logic [4:0]    h_cnt;
    logic [3:0]    v_cnt;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [15:0]   fb_wdata;
    logic          frame_done;
    logic          fb_bank_rd;
    logic [7:0]    drop_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_wr;
    int n_dn;

    ov7670_fb_writer #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .SCALE_SHIFT (1),
        .DATA_WIDTH  (16)
    ) dut (
        .cam_PCLK   (clk),
        .cam_RESETn (rst_n),
        .cam_VSYNC  (vsync),
        .pix_valid  (pix_valid),
        .rgb565     (rgb565),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .frame_done (frame_done),
        .fb_bank_rd (fb_bank_rd),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},      32'(fb_we),      32'd0);
        check({tag, "_addr"},    32'(fb_addr),    32'd0);
        check({tag, "_wdata"},   32'(fb_wdata),   32'd0);
        check({tag, "_done"},    32'(frame_done), 32'd0);
        check({tag, "_bank_rd"}, 32'(fb_bank_rd), 32'd0);
        check({tag, "_drop"},    32'(drop_cnt),   32'd0);
    endtask

    // Streams rows 0..rows-1, columns 0..W (W itself is out of range),
    // back to back, checking every output cycle against the expected write.
    task automatic run_rows(input int rows, input int base, output int writes, output int dones);
        int kept;
        kept   = 0;
        writes = 0;
        dones  = 0;
        for (int v = 0; v < rows; v++) begin
            for (int h = 0; h <= W; h++) begin
                logic        exp_keep;
                logic [15:0] pix;
                pix       = 16'((v << 8) | h) ^ 16'hA5A5;
                h_cnt     = 5'(h);
                v_cnt     = 4'(v);
                rgb565    = pix;
                pix_valid = 1'b1;
                tick();
                exp_keep = (h < W) && (h % 2 == 0) && (v % 2 == 0);
                check("fb_we", 32'(fb_we), 32'(exp_keep));
                if (exp_keep) begin
                    check("fb_addr",    32'(fb_addr),    32'(base + kept));
                    check("fb_wdata",   32'(fb_wdata),   32'(pix));
                    check("frame_done", 32'(frame_done), 32'(kept == FRAME - 1));
                    kept++;
                end
                if (fb_we)      writes++;
                if (frame_done) dones++;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic one_pixel(input int h, input int v);
        h_cnt     = 5'(h);
        v_cnt     = 4'(v);
        rgb565    = 16'h1234;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        vsync     = 1'b0;
        pix_valid = 1'b0;
        rgb565    = '0;
        h_cnt     = '0;
        v_cnt     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // A pixel before any VSYNC is ignored.
        one_pixel(0, 0);
        check("we_wait_vs", 32'(fb_we), 32'd0);

        // Frame 1: bank 0, addresses 0..31.
        start_frame();
        run_rows(H, 0, n_wr, n_dn);
        check("f1_writes",  32'(n_wr),       32'(FRAME));
        check("f1_dones",   32'(n_dn),       32'd1);
        check("f1_bank_rd", 32'(fb_bank_rd), 32'd0);

        // Pixels after completion but before VSYNC are dropped.
        one_pixel(0, 0);
        check("we_after_done", 32'(fb_we), 32'd0);

        // Frame 2: second bank when double buffered.
        start_frame();
        run_rows(H, DBUF ? FRAME : 0, n_wr, n_dn);
        check("f2_writes",  32'(n_wr),       32'(FRAME));
        check("f2_dones",   32'(n_dn),       32'd1);
        check("f2_bank_rd", 32'(fb_bank_rd), 32'(DBUF));
        check("f2_drop",    32'(drop_cnt),   32'd0);

        // Abort: 8 writes then VSYNC together with a keepable pixel.
        start_frame();
        run_rows(2, 0, n_wr, n_dn);
        check("ab_writes", 32'(n_wr), 32'd8);
        check("ab_dones",  32'(n_dn), 32'd0);
        vsync = 1'b1;
        one_pixel(0, 2);
        check("ab_we",      32'(fb_we),      32'd0);
        check("ab_done",    32'(frame_done), 32'd0);
        check("ab_drop",    32'(drop_cnt),   32'd1);
        check("ab_bank_rd", 32'(fb_bank_rd), 32'(DBUF));

        // Next frame restarts at address 0 of bank 0.
        start_frame();
        run_rows(H, 0, n_wr, n_dn);
        check("f3_writes",  32'(n_wr),       32'(FRAME));
        check("f3_dones",   32'(n_dn),       32'd1);
        check("f3_bank_rd", 32'(fb_bank_rd), 32'd0);
        check("f3_drop",    32'(drop_cnt),   32'd1);

        // 300 more aborts: counter saturates at 255.
        vsync = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            vsync = 1'b0;
            tick();
            vsync = 1'b1;
            tick();
            if (i == 99) check("drop_101", 32'(drop_cnt), 32'd101);
        end
        check("drop_sat", 32'(drop_cnt), 32'd255);

        // Reset for one cycle mid-frame.
        vsync = 1'b0;
        tick();
        one_pixel(0, 0);
        check("pre_rst_we", 32'(fb_we), 32'd1);
        rst_n = 1'b0;
        one_pixel(2, 0);
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        one_pixel(0, 0);
        check("post_rst_we", 32'(fb_we), 32'd0);

        // Clean frame after reset lands in bank 0 from address 0.
        start_frame();
        run_rows(H, 0, n_wr, n_dn);
        check("f4_writes", 32'(n_wr), 32'(FRAME));
        check("f4_dones",  32'(n_dn), 32'd1);
        check("f4_drop",   32'(drop_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
